// File: rtl/adc_pkg.sv
// Shared definitions for the dual SPI ADC capture block: FSM encoding and default timing.
package adc_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StConv  = 3'd1,
        StQuiet = 3'd2,
        StOut1  = 3'd3,
        StOut2  = 3'd4,
        StFin   = 3'd5
    } adc_state_e;

    localparam int unsigned ClkDivDefault    = 4;
    localparam int unsigned FrameBitsDefault = 16;
    localparam int unsigned DataBitsDefault  = 12;
    localparam int unsigned QuietCycDefault  = 3;

endpackage

// File: rtl/dual_adc_capture_if.sv
// Control/result bus between the com controller (master) and the ADC capture block (slave).
interface dual_adc_capture_if #(
    parameter int unsigned DATA_BITS = adc_pkg::DataBitsDefault
);
    logic                 start;
    logic                 stop;
    logic                 modeAdc;
    logic [11:0]          nSamples;
    logic [DATA_BITS-1:0] dataAdc;
    logic                 readyAdc;
    logic                 busy;
    logic                 done;

    modport master (
        output start, stop, modeAdc, nSamples,
        input  dataAdc, readyAdc, busy, done
    );

    modport slave (
        input  start, stop, modeAdc, nSamples,
        output dataAdc, readyAdc, busy, done
    );
endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK generator: divider plus toggle counter for one conversion frame; idles high when disabled.
module adc_sclk_gen #(
    parameter int unsigned CLK_DIV    = adc_pkg::ClkDivDefault,
    parameter int unsigned FRAME_BITS = adc_pkg::FrameBitsDefault
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic sample_en,
    output logic frame_end
);
    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam int unsigned TogW = $clog2(2 * FRAME_BITS);

    logic [DivW-1:0] div_q, div_d;
    logic [TogW-1:0] tog_q, tog_d;
    logic            sclk_q, sclk_d;
    logic            tick;
    logic            last_tog;

    always_comb begin
        tick     = en && (div_q == DivW'(CLK_DIV - 1));
        last_tog = (tog_q == TogW'(2 * FRAME_BITS - 1));
        div_d    = '0;
        tog_d    = '0;
        sclk_d   = 1'b1;
        if (en) begin
            div_d  = tick ? '0 : div_q + DivW'(1);
            sclk_d = tick ? ~sclk_q : sclk_q;
            tog_d  = tog_q;
            if (tick) begin
                tog_d = last_tog ? '0 : tog_q + TogW'(1);
            end
        end
        // Data is taken on the toggle that brings SCLK back high.
        sample_en = tick && !sclk_q;
        frame_end = tick && last_tog;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tog_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            tog_q  <= tog_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/dual_adc_capture.sv
// Burst capture from two 12-bit SPI ADCs; one word (or two in dual mode) per frame.
// ADC_TESTPAT_EN replaces the SDO data with an incrementing 12-bit pattern.
module dual_adc_capture
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV    = ClkDivDefault,
    parameter int unsigned FRAME_BITS = FrameBitsDefault,
    parameter int unsigned DATA_BITS  = DataBitsDefault,
    parameter int unsigned QUIET_CYC  = QuietCycDefault
) (
    input  logic                clk,
    input  logic                rst_n,
    dual_adc_capture_if.slave   bus,
    input  logic                SDOADC1,
    input  logic                SDOADC2,
    output logic                CSADC1,
    output logic                CSADC2,
    output logic                CLKADC1,
    output logic                CLKADC2
);
    localparam int unsigned QuietW = $clog2(QUIET_CYC + 1);

    adc_state_e           state_q, state_d;
    logic [11:0]          frame_q, frame_d;
    logic                 mode_q, mode_d;
    logic [QuietW-1:0]    quiet_q, quiet_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [DATA_BITS-1:0] word1, word2;
    logic                 load_w1, load_w2;
    logic                 sclk, sample_en, frame_end;

    adc_sclk_gen #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == StConv),
        .sclk      (sclk),
        .sample_en (sample_en),
        .frame_end (frame_end)
    );

`ifdef ADC_TESTPAT_EN
    logic [DATA_BITS-1:0] pat_q, pat_d;
    logic                 unused_sdo;

    assign unused_sdo = SDOADC1 ^ SDOADC2 ^ sample_en;
    assign word1      = pat_q;
    assign word2      = pat_q;

    always_comb begin
        pat_d = pat_q;
        if (state_q == StIdle && bus.start) begin
            pat_d = '0;
        end else if (load_w1 || load_w2) begin
            pat_d = pat_q + DATA_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pat_q <= '0;
        else        pat_q <= pat_d;
    end
`else
    logic [FRAME_BITS-1:0] sh1_q, sh1_d, sh2_q, sh2_d;

    always_comb begin
        sh1_d = sh1_q;
        sh2_d = sh2_q;
        if (sample_en) begin
            sh1_d = {sh1_q[FRAME_BITS-2:0], SDOADC1};
            sh2_d = {sh2_q[FRAME_BITS-2:0], SDOADC2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh1_q <= '0;
            sh2_q <= '0;
        end else begin
            sh1_q <= sh1_d;
            sh2_q <= sh2_d;
        end
    end

    // Leading bits of the frame are discarded; the result is the tail of the shift.
    assign word1 = sh1_q[DATA_BITS-1:0];
    assign word2 = sh2_q[DATA_BITS-1:0];
`endif

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        mode_d  = mode_q;
        quiet_d = quiet_q;
        load_w1 = 1'b0;
        load_w2 = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.nSamples != 12'd0) begin
                        frame_d = bus.nSamples;
                        mode_d  = bus.modeAdc;
                        state_d = StConv;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StConv: begin
                if (frame_end) begin
                    quiet_d = '0;
                    state_d = StQuiet;
                end
            end
            StQuiet: begin
                if (quiet_q == QuietW'(QUIET_CYC - 1)) begin
                    load_w1 = 1'b1;
                    state_d = StOut1;
                end else begin
                    quiet_d = quiet_q + QuietW'(1);
                end
            end
            StOut1, StOut2: begin
                if (state_q == StOut1 && mode_q) begin
                    load_w2 = 1'b1;
                    state_d = StOut2;
                end else begin
                    frame_d = frame_q - 12'd1;
                    state_d = (frame_q == 12'd1 || bus.stop) ? StFin : StConv;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d = data_q;
        if (load_w1)      data_d = word1;
        else if (load_w2) data_d = word2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            frame_q <= '0;
            mode_q  <= 1'b0;
            quiet_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
            quiet_q <= quiet_d;
            data_q  <= data_d;
        end
    end

    // CS decodes straight from the state flop so it rises with the async reset.
    assign CSADC1       = (state_q != StConv);
    assign CSADC2       = (state_q != StConv);
    assign CLKADC1      = sclk;
    assign CLKADC2      = sclk;
    assign bus.dataAdc  = data_q;
    assign bus.readyAdc = (state_q == StOut1) || (state_q == StOut2);
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StFin);

endmodule

// File: tb/tb_dual_adc_capture.sv
// Directed bench for dual_adc_capture with a behavioural SPI ADC model on both SDO lines.
module tb_dual_adc_capture;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dual_adc_capture_if bus ();

    logic sdo1 = 1'b0, sdo2 = 1'b0;
    logic cs1, cs2, sck1, sck2;

    dual_adc_capture dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .SDOADC1 (sdo1),
        .SDOADC2 (sdo2),
        .CSADC1  (cs1),
        .CSADC2  (cs2),
        .CLKADC1 (sck1),
        .CLKADC2 (sck2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ADC model: next bit driven on every SCLK falling edge while selected.
    logic [15:0] adc1_word = 16'h0, adc2_word = 16'h0;
    int bit_k = 0;
    always @(negedge cs1) bit_k = 0;
    always @(negedge sck1) begin
        if (!cs1 && bit_k < 16) begin
            sdo1 = adc1_word[15-bit_k];
            sdo2 = adc2_word[15-bit_k];
            bit_k++;
        end
    end

    int   cyc = 0;
    int   words[$], rdy_cyc[$], fall_cyc[$], rise_cyc[$], low_runs[$];
    int   low_run = 0;
    int   done_cyc = 0;
    int   pin_err = 0;
    logic cs_prev = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (bus.readyAdc === 1'b1) begin
            words.push_back(int'(bus.dataAdc));
            rdy_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) done_cyc = cyc;
        if (cs1 === 1'b0) begin
            if (cs_prev) fall_cyc.push_back(cyc);
            low_run++;
        end else begin
            if (!cs_prev) begin
                rise_cyc.push_back(cyc);
                low_runs.push_back(low_run);
            end
            low_run = 0;
        end
        cs_prev = (cs1 !== 1'b0);
        if (cs1 !== cs2 || sck1 !== sck2) pin_err++;
    end

    function automatic logic [31:0] qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_mon();
        words.delete();
        rdy_cyc.delete();
        fall_cyc.delete();
        rise_cyc.delete();
        low_runs.delete();
    endtask

    task automatic do_start(input int n, input logic mode);
        bus.nSamples = 12'(n);
        bus.modeAdc  = mode;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int  k = 0;
        bit  seen = 0;
        while (!seen && k < budget) begin
            @(negedge clk);
            k++;
            if (bus.done === 1'b1) seen = 1;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
    endtask

`ifdef ADC_TESTPAT_EN
    task automatic run_tests();
        clear_mon();
        adc1_word = 16'hFFFF;
        do_start(3, 1'b0);
        wait_done("tp", 1000);
        @(negedge clk);
        check("tp_count", 32'(words.size()), 32'd3);
        check("tp_w0", qget(words, 0), 32'h000);
        check("tp_w1", qget(words, 1), 32'h001);
        check("tp_w2", qget(words, 2), 32'h002);
    endtask
`else
    task automatic run_tests();
        int edges;
        logic prev;

        // Single frame, ADC1 only.
        clear_mon();
        adc1_word = 16'h0ABC;
        adc2_word = 16'h0000;
        do_start(1, 1'b0);
        check("t1_busy_after_start", 32'(bus.busy), 32'd1);
        wait_done("t1", 400);
        @(negedge clk);
        check("t1_busy_after_done", 32'(bus.busy), 32'd0);
        check("t1_count", 32'(words.size()), 32'd1);
        check("t1_word", qget(words, 0), 32'hABC);
        check("t1_cs_low_len", qget(low_runs, 0), 32'd128);
        check("t1_done_lat", 32'(done_cyc) - qget(rdy_cyc, 0), 32'd1);
        check("t1_data_hold", 32'(bus.dataAdc), 32'hABC);

        // Dual mode, two frames; mode/nSamples changes mid-burst must not matter.
        clear_mon();
        adc1_word = 16'h0123;
        adc2_word = 16'h0FED;
        do_start(2, 1'b1);
        bus.modeAdc  = 1'b0;
        bus.nSamples = 12'd1;
        wait_done("t2", 800);
        @(negedge clk);
        check("t2_count", 32'(words.size()), 32'd4);
        check("t2_w0", qget(words, 0), 32'h123);
        check("t2_w1", qget(words, 1), 32'hFED);
        check("t2_w2", qget(words, 2), 32'h123);
        check("t2_w3", qget(words, 3), 32'hFED);
        check("t2_out_b2b", qget(rdy_cyc, 1) - qget(rdy_cyc, 0), 32'd1);
        check("t2_quiet_len", qget(rdy_cyc, 0) - qget(rise_cyc, 0), 32'd3);
        check("t2_next_frame", qget(fall_cyc, 1) - qget(rdy_cyc, 1), 32'd1);

        // Zero-length burst, then leading-bit discard.
        clear_mon();
        do_start(0, 1'b0);
        check("t3_zero_done", 32'(bus.done), 32'd1);
        repeat (3) @(negedge clk);
        check("t3_zero_no_cs", 32'(fall_cyc.size()), 32'd0);
        check("t3_zero_no_word", 32'(words.size()), 32'd0);
        adc1_word = 16'hF555;
        do_start(1, 1'b0);
        wait_done("t3", 400);
        @(negedge clk);
        check("t3_lead_bits", qget(words, 0), 32'h555);

        // Stop raised during the third frame.
        clear_mon();
        adc1_word = 16'h0321;
        do_start(10, 1'b0);
        for (int k = 0; k < 1000 && fall_cyc.size() < 3; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        bus.stop = 1'b1;
        wait_done("t4", 400);
        bus.stop = 1'b0;
        @(negedge clk);
        check("t4_count", 32'(words.size()), 32'd3);
        check("t4_w2", qget(words, 2), 32'h321);

        // Stop held at start: exactly one frame.
        clear_mon();
        bus.stop = 1'b1;
        do_start(5, 1'b0);
        wait_done("t4b", 400);
        bus.stop = 1'b0;
        @(negedge clk);
        check("t4b_count", 32'(words.size()), 32'd1);

        // Reset at the ninth SCLK edge.
        clear_mon();
        adc1_word = 16'h0AAA;
        do_start(1, 1'b0);
        edges = 0;
        prev  = sck1;
        for (int k = 0; k < 200 && edges < 9; k++) begin
            @(negedge clk);
            if (sck1 !== prev) edges++;
            prev = sck1;
        end
        check("t5_edge9", 32'(edges), 32'd9);
        #1 rst_n = 1'b0;
        #1;
        check("t5_cs_async", {30'd0, cs1, cs2}, 32'd3);
        check("t5_sclk_async", {30'd0, sck1, sck2}, 32'd3);
        check("t5_data_reset", 32'(bus.dataAdc), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_no_word", 32'(words.size()), 32'd0);
        adc1_word = 16'h0777;
        do_start(1, 1'b0);
        wait_done("t5", 400);
        @(negedge clk);
        check("t5_restart_count", 32'(words.size()), 32'd1);
        check("t5_restart_word", qget(words, 0), 32'h777);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.modeAdc  = 1'b0;
        bus.nSamples = 12'd0;
        repeat (3) @(negedge clk);
        check("rst_cs", {30'd0, cs1, cs2}, 32'd3);
        check("rst_sclk", {30'd0, sck1, sck2}, 32'd3);
        check("rst_data", 32'(bus.dataAdc), 32'd0);
        check("rst_ready", 32'(bus.readyAdc), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_tests();
        check("pin_mirror", 32'(pin_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
